// File: rtl/mfcc_frame_scheduler.sv
// Frame-level sequencer for the MFCC pipeline. It counts PCM samples into frames, then runs the
// WINDOW -> FFT -> MEL -> DCT stages in turn, and flags overruns and stage hangs.
module mfcc_frame_scheduler #(
    parameter int FRAME_SIZE    = 400,
    parameter int FRAME_MOVE    = 160,
    parameter int STAGE_TIMEOUT = 65535,
    parameter int IDX_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic             pcm_ready_i,
    input  logic             clear_i,
    output logic             win_start_o,
    input  logic             win_done_i,
    output logic             fft_start_o,
    input  logic             fft_done_i,
    output logic             mel_start_o,
    input  logic             mel_done_i,
    output logic             dct_start_o,
    input  logic             dct_done_i,
    output logic             frame_valid_o,
    output logic [IDX_W-1:0] frame_idx_o,
    output logic             busy_o,
    output logic             overrun_o,
    output logic             timeout_o,
    output logic [7:0]       drop_count_o
);

    localparam int CNT_MAX = (FRAME_SIZE > FRAME_MOVE) ? FRAME_SIZE : FRAME_MOVE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TMR_W   = $clog2(STAGE_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] SIZE_C   = CNT_W'(FRAME_SIZE);
    localparam logic [CNT_W-1:0] MOVE_C   = CNT_W'(FRAME_MOVE);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(STAGE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WIN,
        ST_FFT,
        ST_MEL,
        ST_DCT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] acc_cnt;
    logic [CNT_W-1:0] need;
    logic [TMR_W-1:0] timer;

    logic       frame_evt;
    logic       overrun_evt;
    logic       stage_done;
    logic       stage_first;
    logic       advance;
    logic       expire;
    logic [7:0] drop_base;
    logic [8:0] drop_sum;
    logic [7:0] drop_next;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        stage_done = 1'b0;
        case (state)
            ST_WIN:  stage_done = win_done_i;
            ST_FFT:  stage_done = fft_done_i;
            ST_MEL:  stage_done = mel_done_i;
            ST_DCT:  stage_done = dct_done_i;
            default: stage_done = 1'b0;
        endcase

        // A stage's start pulse marks its first cycle, and its done is ignored in that cycle.
        stage_first = win_start_o | fft_start_o | mel_start_o | dct_start_o;
        advance     = stage_done && !stage_first;
        expire      = (state != ST_IDLE) && !advance && (timer == TMR_LAST);

        frame_evt   = enable_i && pcm_ready_i && (acc_cnt == need - CNT_W'(1));
        overrun_evt = frame_evt && (state != ST_IDLE);

        // A clear and a new drop in the same cycle: the clear applies first, then the new drop counts.
        drop_base = clear_i ? 8'd0 : drop_count_o;
        drop_sum  = {1'b0, drop_base} + {8'd0, overrun_evt} + {8'd0, expire};
        drop_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            acc_cnt       <= '0;
            need          <= SIZE_C;
            timer         <= '0;
            win_start_o   <= 1'b0;
            fft_start_o   <= 1'b0;
            mel_start_o   <= 1'b0;
            dct_start_o   <= 1'b0;
            frame_valid_o <= 1'b0;
            frame_idx_o   <= '0;
            busy_o        <= 1'b0;
            overrun_o     <= 1'b0;
            timeout_o     <= 1'b0;
            drop_count_o  <= 8'd0;
        end else begin
            win_start_o   <= 1'b0;
            fft_start_o   <= 1'b0;
            mel_start_o   <= 1'b0;
            dct_start_o   <= 1'b0;
            frame_valid_o <= 1'b0;

            if (!enable_i) begin
                acc_cnt <= '0;
                need    <= SIZE_C;
            end else if (pcm_ready_i) begin
                if (frame_evt) begin
                    acc_cnt <= '0;
                    need    <= MOVE_C;
                end else begin
                    acc_cnt <= acc_cnt + CNT_W'(1);
                end
            end

            case (state)
                ST_IDLE: begin
                    if (frame_evt) begin
                        state       <= ST_WIN;
                        win_start_o <= 1'b1;
                        busy_o      <= 1'b1;
                        timer       <= '0;
                    end
                end
                default: begin
                    if (advance) begin
                        timer <= '0;
                        case (state)
                            ST_WIN: begin
                                state       <= ST_FFT;
                                fft_start_o <= 1'b1;
                            end
                            ST_FFT: begin
                                state       <= ST_MEL;
                                mel_start_o <= 1'b1;
                            end
                            ST_MEL: begin
                                state       <= ST_DCT;
                                dct_start_o <= 1'b1;
                            end
                            default: begin
                                state         <= ST_IDLE;
                                busy_o        <= 1'b0;
                                frame_valid_o <= 1'b1;
                                frame_idx_o   <= frame_idx_o + IDX_W'(1);
                            end
                        endcase
                    end else if (expire) begin
                        // A hung stage aborts the frame; no coefficients are reported for it.
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                        timer  <= '0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
            endcase

            overrun_o    <= overrun_evt | (overrun_o & ~clear_i);
            timeout_o    <= expire | (timeout_o & ~clear_i);
            drop_count_o <= drop_next;
        end
    end

endmodule

// File: tb/tb_mfcc_frame_scheduler.sv
// Self-checking bench for mfcc_frame_scheduler. Stage cores are modelled by a responder, and
// expected frame indices go through a scoreboard queue.
`timescale 1ns/1ps
module tb_mfcc_frame_scheduler;

    localparam int IDX_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable_i = 1'b0;
    logic             pcm_ready_i = 1'b0;
    logic             clear_i = 1'b0;
    logic             win_start_o, fft_start_o, mel_start_o, dct_start_o;
    logic             win_done_i, fft_done_i, mel_done_i, dct_done_i;
    logic             frame_valid_o;
    logic [IDX_W-1:0] frame_idx_o;
    logic             busy_o, overrun_o, timeout_o;
    logic [7:0]       drop_count_o;

    logic [3:0] resp_done = '0;
    logic [3:0] man_done  = '0;
    bit         hold [4]  = '{0, 0, 0, 0};
    int         lat  [4]  = '{3, 3, 3, 3};
    int         cnt  [4]  = '{0, 0, 0, 0};
    logic [3:0] starts;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int wins = 0;
    int valids = 0;
    int win_c = 0, fft_c = 0, mel_c = 0, dct_c = 0, val_c = 0;
    int sb[$];

    assign win_done_i = resp_done[0] | man_done[0];
    assign fft_done_i = resp_done[1] | man_done[1];
    assign mel_done_i = resp_done[2] | man_done[2];
    assign dct_done_i = resp_done[3] | man_done[3];
    assign starts     = {dct_start_o, mel_start_o, fft_start_o, win_start_o};

    mfcc_frame_scheduler #(
        .FRAME_SIZE   (400),
        .FRAME_MOVE   (160),
        .STAGE_TIMEOUT(100),
        .IDX_W        (IDX_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable_i     (enable_i),
        .pcm_ready_i  (pcm_ready_i),
        .clear_i      (clear_i),
        .win_start_o  (win_start_o),
        .win_done_i   (win_done_i),
        .fft_start_o  (fft_start_o),
        .fft_done_i   (fft_done_i),
        .mel_start_o  (mel_start_o),
        .mel_done_i   (mel_done_i),
        .dct_start_o  (dct_start_o),
        .dct_done_i   (dct_done_i),
        .frame_valid_o(frame_valid_o),
        .frame_idx_o  (frame_idx_o),
        .busy_o       (busy_o),
        .overrun_o    (overrun_o),
        .timeout_o    (timeout_o),
        .drop_count_o (drop_count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // n one-per-cycle strobes; optional clear_i on the last one. Returns in the cycle after the last.
    task automatic strobes(input int n, input bit en, input bit clr_last);
        for (int i = 0; i < n; i++) begin
            tick();
            pcm_ready_i = 1'b1;
            enable_i    = en;
            clear_i     = clr_last && (i == n - 1);
        end
        tick();
        pcm_ready_i = 1'b0;
        clear_i     = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy_o && k < 300) begin
            tick();
            k++;
        end
        check("idle_reached", busy_o, 0);
        tick();
    endtask

    // Stage responder: done arrives lat cycles after a start pulse unless that stage is held.
    initial begin
        forever begin
            @(negedge clk);
            for (int s = 0; s < 4; s++) begin
                resp_done[s] = 1'b0;
                if (rst) begin
                    cnt[s] = 0;
                end else begin
                    if (cnt[s] > 0) begin
                        cnt[s]--;
                        if (cnt[s] == 0) resp_done[s] = 1'b1;
                    end
                    if (starts[s] && !hold[s]) cnt[s] = lat[s];
                end
            end
        end
    end

    // Output monitor: timestamps start pulses and checks each frame_valid against the scoreboard.
    initial begin
        int exp_idx;
        forever begin
            @(negedge clk);
            cyc++;
            if (win_start_o) begin wins++; win_c = cyc; end
            if (fft_start_o) fft_c = cyc;
            if (mel_start_o) mel_c = cyc;
            if (dct_start_o) dct_c = cyc;
            if (frame_valid_o) begin
                valids++;
                val_c = cyc;
                if (sb.size() == 0) begin
                    check("unexpected_frame_valid", 1, 0);
                end else begin
                    exp_idx = sb.pop_front();
                    check("frame_idx", 32'(frame_idx_o), exp_idx);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        int n;
        bit en;
        bit exp_start;
        int exp_idx;
    } vec_t;

    initial begin
        vec_t vecs [9];
        int   w0, v0, k, s_cyc;

        vecs[0] = '{399, 1'b1, 1'b0, 0};
        vecs[1] = '{1,   1'b1, 1'b1, 1};
        vecs[2] = '{160, 1'b1, 1'b1, 2};
        vecs[3] = '{100, 1'b1, 1'b0, 0};
        vecs[4] = '{1,   1'b0, 1'b0, 0};
        vecs[5] = '{159, 1'b1, 1'b0, 0};
        vecs[6] = '{241, 1'b1, 1'b1, 3};
        vecs[7] = '{159, 1'b1, 1'b0, 0};
        vecs[8] = '{1,   1'b1, 1'b1, 4};

        // Reset state
        tick();
        tick();
        check("rst_busy", busy_o, 0);
        check("rst_win_start", win_start_o, 0);
        check("rst_frame_valid", frame_valid_o, 0);
        check("rst_frame_idx", frame_idx_o, 0);
        check("rst_overrun", overrun_o, 0);
        check("rst_timeout", timeout_o, 0);
        check("rst_drop", drop_count_o, 0);
        rst = 1'b0;
        tick();

        // First frame, hop, enable-drop handling
        foreach (vecs[i]) begin
            w0 = wins;
            if (vecs[i].exp_start) sb.push_back(vecs[i].exp_idx);
            strobes(vecs[i].n, vecs[i].en, 1'b0);
            check($sformatf("row%0d_win_start", i), win_start_o, 32'(vecs[i].exp_start));
            check($sformatf("row%0d_win_count", i), wins - w0, vecs[i].exp_start);
            check($sformatf("row%0d_overrun", i), overrun_o, 0);
            wait_idle();
        end
        check("fft_after_win", fft_c - win_c, 4);
        check("mel_after_fft", mel_c - fft_c, 4);
        check("dct_after_mel", dct_c - mel_c, 4);
        check("valid_after_win", val_c - win_c, 16);
        check("idx_after_table", frame_idx_o, 4);

        // Stage timeout: MEL never finishes
        hold[2] = 1'b1;
        v0 = valids;
        strobes(160, 1'b1, 1'b0);
        check("t4_win_start", win_start_o, 1);
        k = 0;
        while (!mel_start_o && k < 40) begin
            tick();
            k++;
        end
        check("t4_mel_start_seen", mel_start_o, 1);
        s_cyc = cyc;
        repeat (99) tick();
        check("t4_busy_before_abort", busy_o, 1);
        check("t4_timeout_before_abort", timeout_o, 0);
        tick();
        check("t4_abort_delay", cyc - s_cyc, 100);
        check("t4_busy", busy_o, 0);
        check("t4_timeout", timeout_o, 1);
        check("t4_drop", drop_count_o, 1);
        check("t4_idx", frame_idx_o, 4);
        check("t4_no_valid", valids - v0, 0);
        hold[2] = 1'b0;

        // Overrun while FFT is held, with clear_i in the same cycle as the overrun
        lat[0]  = 90;
        hold[1] = 1'b1;
        sb.push_back(5);
        strobes(160, 1'b1, 1'b0);
        check("t3_win_start", win_start_o, 1);
        w0 = wins;
        strobes(160, 1'b1, 1'b1);
        check("t3_in_fft", (fft_c > win_c) ? 1 : 0, 1);
        check("t3_busy", busy_o, 1);
        check("t3_overrun", overrun_o, 1);
        check("t3_timeout_cleared", timeout_o, 0);
        check("t3_drop_clear_and_set", drop_count_o, 1);
        check("t3_no_new_win", wins - w0, 0);
        man_done[1] = 1'b1;
        tick();
        man_done[1] = 1'b0;
        hold[1]     = 1'b0;
        lat[0]      = 3;
        wait_idle();
        check("t3_idx", frame_idx_o, 5);

        // Early win_done in its start cycle and stray fft_done during WIN
        hold[0] = 1'b1;
        sb.push_back(6);
        strobes(160, 1'b1, 1'b0);
        check("t6_win_start", win_start_o, 1);
        man_done[0] = 1'b1;
        man_done[1] = 1'b1;
        tick();
        man_done[0] = 1'b0;
        check("t6_early_done_ignored", fft_start_o, 0);
        check("t6_busy", busy_o, 1);
        tick();
        man_done[1] = 1'b0;
        check("t6_stray_fft_ignored", fft_start_o, 0);
        check("t6_no_mel", mel_start_o, 0);
        man_done[0] = 1'b1;
        tick();
        man_done[0] = 1'b0;
        hold[0]     = 1'b0;
        check("t6_fft_start", fft_start_o, 1);
        wait_idle();
        check("t6_idx", frame_idx_o, 6);

        // Reset during FFT start pulse
        strobes(160, 1'b1, 1'b0);
        k = 0;
        while (!fft_start_o && k < 40) begin
            tick();
            k++;
        end
        check("t5_fft_start_seen", fft_start_o, 1);
        rst = 1'b1;
        #1;
        check("t5_fft_start", fft_start_o, 0);
        check("t5_busy", busy_o, 0);
        check("t5_idx", frame_idx_o, 0);
        check("t5_overrun", overrun_o, 0);
        check("t5_drop", drop_count_o, 0);
        tick();
        rst = 1'b0;
        w0 = wins;
        strobes(399, 1'b1, 1'b0);
        check("t5_no_frame_at_399", wins - w0, 0);
        sb.push_back(1);
        strobes(1, 1'b1, 1'b0);
        check("t5_frame_at_400", win_start_o, 1);
        wait_idle();
        check("t5_idx_after", frame_idx_o, 1);

        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
